// File: rtl/ifetch_responder.sv
// Instruction-memory responder behind the core fetch port.
// Define IFETCH_RESPONDER_ERR_EN to enable misalignment/range faulting.
module ifetch_responder #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] BASE = 32'h80000000,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter int QDEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [XLEN-1:0]                req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ILEN-1:0]                rsp_inst,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [ILEN-1:0]                ld_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int EW = ILEN + 1;
  localparam logic [ILEN-1:0] EBREAK = ILEN'(32'h00100073);

  logic [ILEN-1:0] mem_q [DEPTH_WORDS];
  logic [EW-1:0]   fifo_q [QDEPTH];

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fc_q, fc_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;

  logic            acc, pop, fault;
  logic [XLEN-1:0] off;
  logic [AW-1:0]   idx;
  logic [EW-1:0]   in_e, fin_e;
  logic            fin_v;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = !rst && (cnt_q < CW'(QDEPTH));
  assign acc       = req_valid && req_ready;
  assign rsp_valid = !rst && (fc_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  assign off = req_addr - BASE;
  assign idx = off[AW+1:2];

`ifdef IFETCH_RESPONDER_ERR_EN
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(4 * DEPTH_WORDS);
  assign fault = (req_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
`else
  logic unused_bits;
  assign unused_bits = ^{off[XLEN-1:AW+2], off[1:0]};
  assign fault = 1'b0;
`endif

  assign in_e = fault ? {1'b1, EBREAK} : {1'b0, mem_q[idx]};

  // Loader port writes the store; never reset, honoured during reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign fin_v = acc;
      assign fin_e = in_e;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv_q;
      logic [EW-1:0]      pe_q [LATENCY-1];

      // Fixed-length delay line; never stalls, flushed by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      // Payload follows the valid bits; no reset needed.
      always_ff @(posedge clk) begin
        pe_q[0] <= in_e;
        for (int i = 1; i < LATENCY - 1; i++) pe_q[i] <= pe_q[i-1];
      end

      assign fin_v = pv_q[LATENCY-2];
      assign fin_e = pe_q[LATENCY-2];
    end
  endgenerate

  // Next-state for credit count and FIFO pointers.
  always_comb begin
    cnt_d = cnt_q;
    fc_d  = fc_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (acc && !pop) cnt_d = cnt_q + CW'(1);
    else if (!acc && pop) cnt_d = cnt_q - CW'(1);
    if (fin_v && !pop) fc_d = fc_q + CW'(1);
    else if (!fin_v && pop) fc_d = fc_q - CW'(1);
    if (fin_v) wp_d = nxt(wp_q);
    if (pop) rp_d = nxt(rp_q);
  end

  // Control state register with synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      fc_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      fc_q  <= fc_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  // Response FIFO storage; credits guarantee no overflow.
  always_ff @(posedge clk) begin
    if (!rst && fin_v) fifo_q[wp_q] <= fin_e;
  end

  assign rsp_inst = rsp_valid ? fifo_q[rp_q][ILEN-1:0] : '0;
  assign rsp_err  = rsp_valid ? fifo_q[rp_q][ILEN] : 1'b0;
endmodule

// File: tb/tb_ifetch_responder.sv
// Bench for ifetch_responder: queue-based reference model
// checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_ifetch_responder;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int QD  = 4;
  localparam logic [31:0] EBRK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic        rsp_valid, rsp_ready, rsp_err, ld_en;
  logic [31:0] req_addr, rsp_inst, ld_data;
  logic [9:0]  ld_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mm [DW];

  always #5 clk = ~clk;

  ifetch_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  function automatic logic [31:0] wval(input int i);
    return (i == 0) ? 32'h00000413 : (32'hA5000000 | 32'(i));
  endfunction

  function automatic ent_t predict(input logic [31:0] a);
    ent_t e;
    logic [31:0] d;
    d = a - BASE;
    e.t = cyc;
    e.err = 1'b0;
    e.inst = mm[int'((d >> 2) % 32'(DW))];
`ifdef IFETCH_RESPONDER_ERR_EN
    if (a[1:0] != 2'b00 || d >= 32'(4 * DW)) begin
      e.err = 1'b1;
      e.inst = EBRK;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: advances at every rising edge.
  initial begin
    bit   er, ev, a, p;
    ent_t e;
    forever begin
      @(posedge clk);
      er = !rst && q.size() < QD;
      ev = !rst && q.size() > 0 && (q[0].t + LAT <= cyc);
      a = req_valid && er;
      p = ev && rsp_ready;
      if (a) e = predict(req_addr);
      if (rst) q.delete();
      else begin
        if (p) void'(q.pop_front());
        if (a) q.push_back(e);
      end
      if (ld_en) mm[ld_idx] = ld_data;
      cyc++;
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    bit er, ev;
    forever begin
      @(negedge clk);
      er = !rst && q.size() < QD;
      ev = !rst && q.size() > 0 && (q[0].t + LAT <= cyc);
      chk("m_ready", 32'(req_ready), 32'(er));
      chk("m_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("m_inst", rsp_inst, q[0].inst);
        chk("m_err", 32'(rsp_err), 32'(q[0].err));
      end
      if (rst) begin
        chk("m_rst_inst", rsp_inst, 32'h0);
        chk("m_rst_err", 32'(rsp_err), 32'h0);
      end
    end
  end

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 50), 32'h1);
  endtask

  task automatic single(input string nm, input logic [31:0] a,
                        input logic [31:0] wi, input logic we);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = a;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, 32'(rsp_valid), 32'h0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'h1);
    chk({nm, "_inst"}, rsp_inst, wi);
    chk({nm, "_err"}, 32'(rsp_err), 32'(we));
    step();
  endtask

  initial begin
    int n, first, last;
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr = BASE;
    rsp_ready = 1'b0;
    ld_en = 1'b1;
    ld_idx = '0;
    ld_data = wval(0);

    // 1: reset held while the loader fills words 0..15
    for (int i = 0; i < 16; i++) begin
      ld_idx = 10'(i);
      ld_data = wval(i);
      @(negedge clk);
      chk("t1_ready_rst", 32'(req_ready), 32'h0);
      chk("t1_valid_rst", 32'(rsp_valid), 32'h0);
      step();
    end
    ld_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", 32'(req_ready), 32'h1);
    step();
    drain();

    // 2: single fetch, latency 2
    single("t2", BASE, 32'h00000413, 1'b0);

    // 3: backpressure fills the credit window
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr = BASE + 32'(4 * i);
      @(negedge clk);
      if (req_ready) n++;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("t3_accepted", 32'(n), 32'd4);
    chk("t3_ready_full", 32'(req_ready), 32'h0);
    step();
    step();
    step();
    @(negedge clk);
    chk("t3_hold_valid", 32'(rsp_valid), 32'h1);
    chk("t3_hold_inst", rsp_inst, 32'h00000413);
    rsp_ready = 1'b1;
    step();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("t3_order", rsp_inst, wval(k));
      step();
    end
    drain();

    // 4: streaming throughput
    rsp_ready = 1'b1;
    n = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8);
      req_addr = BASE + 32'(4 * c);
      @(negedge clk);
      if (rsp_valid) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
      step();
    end
    chk("t4_count", 32'(n), 32'd8);
    chk("t4_first", 32'(first), 32'd2);
    chk("t4_span", 32'(last - first), 32'd7);
    drain();

    // 5: misaligned and out-of-range addresses
`ifdef IFETCH_RESPONDER_ERR_EN
    single("t5_mis", BASE + 32'h2, EBRK, 1'b1);
    single("t5_end", BASE + 32'h1000, EBRK, 1'b1);
    single("t5_low", BASE - 32'h4, EBRK, 1'b1);
`else
    single("t5_mis", BASE + 32'h2, 32'h00000413, 1'b0);
    single("t5_end", BASE + 32'h1000, 32'h00000413, 1'b0);
    single("t5_wrap", BASE + 32'h1004, 32'hA5000001, 1'b0);
`endif

    // read-during-load returns old word; later fetch sees new word
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = BASE + 32'd20;
    ld_en = 1'b1;
    ld_idx = 10'd5;
    ld_data = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    ld_en = 1'b0;
    step();
    @(negedge clk);
    chk("t5_rdw_old", rsp_inst, 32'hA5000005);
    step();
    single("t5_rdw_new", BASE + 32'd20, 32'hDEADBEEF, 1'b0);

    // 6: reset drops in-flight responses
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr = BASE + 32'(4 * (i + 2));
      step();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
      step();
    end
    single("t6_after", BASE + 32'h4, 32'hA5000001, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
